ahb3lite_sram_slave: RTL and testbench

AHB3-Lite slave that fronts a single-port, word-organised on-chip SRAM. It sits on the AHB3-Lite bus as a zero-wait-state memory target. It accepts byte, halfword and word reads and writes, and always responds OKAY. Burst and protection attributes are accepted but do not change its behaviour.

---
 rtl/ahb3lite_sram_slave_if.sv | 30 +++
 rtl/ahb3lite_sram_slave.sv | 109 ++++++++++
 tb/tb_ahb3lite_sram_slave.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ahb3lite_sram_slave_if.sv
// AHB3-Lite signal bundle between a bus master (or decoder) and the SRAM slave.
interface ahb3lite_sram_slave_if #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
);
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HREADYOUT;
  logic                  HREADY;
  logic                  HRESP;

  // Handshake: an address phase is taken when HSEL & HREADY & HTRANS[1] at the
  // rising edge; its data phase completes at the next edge where HREADY is 1.
  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb3lite_sram_slave.sv
// Zero-wait-state AHB3-Lite slave fronting a word-organised single-port SRAM,
// with byte-lane writes and read-after-write forwarding.
module ahb3lite_sram_slave #(
  parameter int MEM_SIZE   = 4096,
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahb3lite_sram_slave_if.slave bus
);

  localparam int AW    = $clog2(MEM_SIZE);
  localparam int DEPTH = MEM_SIZE / 4;
  localparam int IW    = (AW > 2) ? AW - 2 : 1;

  logic [HADDR_SIZE-1:0] haddr;
  logic [HDATA_SIZE-1:0] wdata;
  logic [31:0]           mem [0:DEPTH-1];

  logic          accept;
  logic [IW-1:0] addr_idx;
  logic [3:0]    addr_mask;

  logic          dp_valid;
  logic          dp_write;
  logic [IW-1:0] dp_idx;
  logic [3:0]    dp_mask;
  logic          commit;

  logic [31:0]   rd_word;
  logic [31:0]   rdata;
  logic          unused_ok;

  assign haddr  = bus.HADDR;
  assign wdata  = bus.HWDATA;
  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];

  // Upper address bits are dropped so addresses alias modulo MEM_SIZE.
  generate
    if (MEM_SIZE > 4) begin : g_idx
      assign addr_idx = haddr[AW-1:2];
    end else begin : g_idx_one
      assign addr_idx = '0;
    end
  endgenerate

  always_comb begin
    addr_mask = 4'b1111;
    case (bus.HSIZE)
      3'd0:    addr_mask = 4'b0001 << haddr[1:0];
      3'd1:    addr_mask = haddr[1] ? 4'b1100 : 4'b0011;
      default: addr_mask = 4'b1111;
    endcase
  end

  // Data-phase registers advance only when the bus is ready, so a stretched
  // HREADY from another slave freezes both capture and the pending write.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_mask  <= '0;
    end else if (bus.HREADY) begin
      dp_valid <= accept;
      if (accept) begin
        dp_write <= bus.HWRITE;
        dp_idx   <= addr_idx;
        dp_mask  <= addr_mask;
      end
    end
  end

  assign commit = dp_valid & dp_write & bus.HREADY;

  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (dp_mask[i]) mem[dp_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // A read launched while a write to the same word commits sees the merged word.
  always_comb begin
    rd_word = mem[addr_idx];
    if (commit && (dp_idx == addr_idx)) begin
      for (int i = 0; i < 4; i++) begin
        if (dp_mask[i]) rd_word[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rdata <= '0;
    end else if (accept && !bus.HWRITE) begin
      rdata <= rd_word;
    end
  end

  assign bus.HRDATA    = rdata;
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;

  assign unused_ok = ^{haddr, bus.HTRANS[0], bus.HBURST, bus.HPROT};

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Self-checking bench for ahb3lite_sram_slave: directed scenarios plus random
// pipelined traffic checked against a byte-array memory model.
module tb_ahb3lite_sram_slave;

  localparam int MEM_SIZE = 4096;

  logic HCLK;
  logic HRESETn;

  ahb3lite_sram_slave_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus ();

  ahb3lite_sram_slave #(
    .MEM_SIZE  (MEM_SIZE),
    .HADDR_SIZE(32),
    .HDATA_SIZE(32)
  ) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus)
  );

  // clock / reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: byte-addressed memory plus the one outstanding transfer
  logic [7:0]  model_mem [MEM_SIZE];
  logic        p_valid;
  logic        p_write;
  logic [31:0] p_addr;
  logic [2:0]  p_size;
  logic [31:0] p_data;
  logic [31:0] exp_rd;

  int total;
  int bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    int unsigned a;
    int unsigned base;
    int unsigned nb;
    a = addr % MEM_SIZE;
    if (size == 3'd0) begin
      nb = 1; base = a;
    end else if (size == 3'd1) begin
      nb = 2; base = a & ~32'd1;
    end else begin
      nb = 4; base = a & ~32'd3;
    end
    for (int k = 0; k < int'(nb); k++) begin
      model_mem[base + k] = data[8*((base + k) % 4) +: 8];
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    logic [31:0] w;
    int unsigned base;
    base = (addr % MEM_SIZE) & ~32'd3;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = model_mem[base + k];
    return w;
  endfunction

  // driver: one bus cycle, address phase given by the arguments
  task automatic bus_cycle(input logic sel, input logic [1:0] trans, input logic wr,
                           input logic [31:0] addr, input logic [2:0] size,
                           input logic rdy, input logic [31:0] wdata);
    bus.HSEL   = sel;
    bus.HTRANS = trans;
    bus.HWRITE = wr;
    bus.HADDR  = addr;
    bus.HSIZE  = size;
    bus.HREADY = rdy;
    bus.HBURST = 3'($urandom);
    bus.HPROT  = 4'($urandom);
    bus.HWDATA = (p_valid && p_write) ? p_data : $urandom;
    @(posedge HCLK);
    if (rdy) begin
      if (p_valid && p_write) model_write(p_addr, p_size, p_data);
      p_valid = sel && trans[1];
      if (p_valid) begin
        p_write = wr;
        p_addr  = addr;
        p_size  = size;
        p_data  = wdata;
        if (!wr) exp_rd = model_read(addr);
      end
    end
    #1;
    chk("hrdata", bus.HRDATA, exp_rd);
    chk("hresp", 32'(bus.HRESP), 32'd0);
    chk("hreadyout", 32'(bus.HREADYOUT), 32'd1);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    bus_cycle(1'b1, 2'b10, 1'b1, addr, size, 1'b1, data);
  endtask

  task automatic rd(input logic [31:0] addr);
    bus_cycle(1'b1, 2'b10, 1'b0, addr, 3'd2, 1'b1, 32'd0);
  endtask

  task automatic idle();
    bus_cycle(1'b1, 2'b00, 1'b0, 32'd0, 3'd0, 1'b1, 32'd0);
  endtask

  task automatic apply_reset(input int cycles);
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HREADY = 1'b1;
    HRESETn    = 1'b0;
    p_valid    = 1'b0;
    p_write    = 1'b0;
    exp_rd     = 32'd0;
    #1;
    chk("rst_hrdata", bus.HRDATA, 32'd0);
    chk("rst_hresp", 32'(bus.HRESP), 32'd0);
    chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    repeat (cycles) @(posedge HCLK);
    #1;
    chk("rst_hold_hrdata", bus.HRDATA, 32'd0);
    HRESETn = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.HADDR  = '0;
    bus.HWDATA = '0;
    bus.HSIZE  = 3'd0;
    bus.HBURST = 3'd0;
    bus.HPROT  = 4'd0;
    apply_reset(3);

    // give every word of the test region a known value
    for (int a = 0; a < 128; a += 4) wr(32'(a), 3'd2, 32'h1000_0000 | 32'(a));
    idle();

    wr(32'h10, 3'd2, 32'hCAFEDADA);
    idle();
    rd(32'h10);
    chk("word_rd", bus.HRDATA, 32'hCAFEDADA);
    idle();

    wr(32'h20, 3'd2, 32'h0);
    wr(32'h20, 3'd0, 32'h0000_0011);
    wr(32'h21, 3'd0, 32'h0000_2200);
    wr(32'h22, 3'd0, 32'h0033_0000);
    wr(32'h23, 3'd0, 32'h4400_0000);
    rd(32'h20);
    chk("byte_lanes", bus.HRDATA, 32'h44332211);
    idle();

    wr(32'h30, 3'd2, 32'h12345678);
    wr(32'h32, 3'd1, 32'hBEEF_0000);
    idle();
    rd(32'h30);
    chk("halfword_hi", bus.HRDATA, 32'hBEEF5678);
    idle();

    wr(32'h40, 3'd2, 32'hA5A5A5A5);
    rd(32'h40);
    chk("raw_forward", bus.HRDATA, 32'hA5A5A5A5);
    idle();

    wr(32'h50, 3'd2, 32'h01020304);
    idle();
    bus_cycle(1'b1, 2'b00, 1'b1, 32'h50, 3'd2, 1'b1, 32'hFFFF_FFFF);
    bus_cycle(1'b1, 2'b01, 1'b1, 32'h50, 3'd2, 1'b1, 32'hFFFF_FFFF);
    bus_cycle(1'b0, 2'b10, 1'b1, 32'h50, 3'd2, 1'b1, 32'hFFFF_FFFF);
    bus_cycle(1'b1, 2'b10, 1'b1, 32'h50, 3'd2, 1'b0, 32'hFFFF_FFFF);
    idle();
    idle();
    rd(32'h50);
    chk("ignored_xfers", bus.HRDATA, 32'h01020304);
    idle();

    wr(32'(MEM_SIZE) + 32'h8, 3'd2, 32'h600DF00D);
    idle();
    rd(32'h8);
    chk("alias", bus.HRDATA, 32'h600DF00D);
    idle();

    // pending write frozen by HREADY low, then committed and forwarded
    wr(32'h60, 3'd2, 32'h77665544);
    bus_cycle(1'b1, 2'b10, 1'b0, 32'h60, 3'd2, 1'b0, 32'd0);
    bus_cycle(1'b1, 2'b10, 1'b0, 32'h60, 3'd2, 1'b0, 32'd0);
    rd(32'h60);
    chk("stall_commit", bus.HRDATA, 32'h77665544);
    idle();

    // reset during a write data phase must drop the write
    wr(32'h70, 3'd2, 32'hDEADBEEF);
    apply_reset(2);
    idle();
    rd(32'h70);
    chk("rst_abort", bus.HRDATA, 32'h1000_0070);
    idle();

    for (int n = 0; n < 500; n++) begin
      logic        sel;
      logic        rdy;
      logic [31:0] addr;
      sel  = ($urandom_range(0, 9) != 0);
      rdy  = ($urandom_range(0, 6) != 0);
      addr = 32'($urandom_range(0, 127)) + 32'(MEM_SIZE) * 32'($urandom_range(0, 3));
      bus_cycle(sel, 2'($urandom_range(0, 3)), 1'($urandom), addr,
                3'($urandom_range(0, 3)), rdy, $urandom);
    end
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
